out_uart_tx: RTL and testbench

//  Downstream consumer of the processor output port (outval1/outval2/outsel/outdisplay, halting).

---
 rtl/out_uart_tx.sv | 243 ++++++++++++++++++++++++
 tb/tb_out_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_uart_tx.sv
// Queues each outdisplay record and prints it as an ASCII line over an 8N1 UART; one "H\r\n" line follows halt.
// Latency: strobe in t -> tx start bit in t+2; each byte is 10*CLKS_PER_BIT+1 cycles; full FIFO drops records (sticky overflow).
module out_uart_tx #(
   parameter int CLKS_PER_BIT = 347,
   parameter int DEPTH_LOG2   = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] outval1,
   input  logic [15:0] outval2,
   input  logic [2:0]  outsel,
   input  logic        outdisplay,
   input  logic        halting,
   output logic        tx,
   output logic        busy,
   output logic        overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [11:0]   BAUD_LAST = 12'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    REC_LAST  = 4'd12;
   localparam logic [3:0]    HALT_LAST = 4'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   function automatic logic [7:0] hex_digit(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Record layout: {outsel[34:32], outval1[31:16], outval2[15:0]}.
   function automatic logic [7:0] line_byte(input logic       halt_mode,
                                            input logic [3:0]  idx,
                                            input logic [34:0] rec);
      logic [7:0] b;
      b = 8'h0A;
      if (halt_mode) begin
         case (idx)
            4'd0:    b = 8'h48;
            4'd1:    b = 8'h0D;
            default: b = 8'h0A;
         endcase
      end else begin
         case (idx)
            4'd0:       b = 8'h30 + {5'd0, rec[34:32]};
            4'd1, 4'd6: b = 8'h20;
            4'd2:       b = hex_digit(rec[31:28]);
            4'd3:       b = hex_digit(rec[27:24]);
            4'd4:       b = hex_digit(rec[23:20]);
            4'd5:       b = hex_digit(rec[19:16]);
            4'd7:       b = hex_digit(rec[15:12]);
            4'd8:       b = hex_digit(rec[11:8]);
            4'd9:       b = hex_digit(rec[7:4]);
            4'd10:      b = hex_digit(rec[3:0]);
            4'd11:      b = 8'h0D;
            default:    b = 8'h0A;
         endcase
      end
      return b;
   endfunction

   logic [34:0]           mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic                  overflow_q;
   logic                  fifo_full, fifo_empty, push, pop;
   logic [34:0]           head;

   assign fifo_full  = (count_q == CNT_FULL);
   assign fifo_empty = (count_q == '0);
   assign push       = outdisplay && !fifo_full;
   assign head       = mem_q[rd_ptr_q];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         // Fullness is judged on the registered count, so a same-cycle pop cannot save the record.
         if (outdisplay && fifo_full) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= {outsel, outval1, outval2};
   end

   logic halting_q, halt_pending_q, halt_sent_q;
   logic halt_rise, halt_take;

   assign halt_rise = halting && !halting_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         halting_q      <= 1'b0;
         halt_pending_q <= 1'b0;
         halt_sent_q    <= 1'b0;
      end else begin
         halting_q <= halting;
         if (halt_take) begin
            halt_pending_q <= 1'b0;
            halt_sent_q    <= 1'b1;
         end else if (halt_rise && !halt_sent_q) begin
            halt_pending_q <= 1'b1;
         end
      end
   end

   state_t      state_q, state_d;
   logic        mode_q, mode_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  last_q, last_d;
   logic [34:0] rec_q, rec_d;
   logic [7:0]  shift_q, shift_d;
   logic [11:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic        tx_q, tx_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= 1'b0;
         idx_q   <= '0;
         last_q  <= '0;
         rec_q   <= '0;
         shift_q <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         rec_q   <= rec_d;
         shift_q <= shift_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      idx_d     = idx_q;
      last_d    = last_q;
      rec_d     = rec_q;
      shift_d   = shift_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      pop       = 1'b0;
      halt_take = 1'b0;

      case (state_q)
         ST_IDLE: begin
            idx_d = '0;
            // A record arriving this cycle counts as queued, so the FSM leaves IDLE on the push edge.
            if (!fifo_empty || push) begin
               state_d = ST_LOAD;
               mode_d  = 1'b0;
               last_d  = REC_LAST;
            end else if (halt_pending_q) begin
               state_d   = ST_LOAD;
               mode_d    = 1'b1;
               last_d    = HALT_LAST;
               halt_take = 1'b1;
            end
         end
         ST_LOAD: begin
            if (!mode_q && idx_q == 4'd0) begin
               pop     = 1'b1;
               rec_d   = head;
               shift_d = line_byte(1'b0, 4'd0, head);
            end else begin
               shift_d = line_byte(mode_q, idx_q, rec_q);
            end
            baud_d  = '0;
            state_d = ST_START;
         end
         ST_START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + 12'd1;
            end
         end
         ST_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = ST_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               baud_d = baud_q + 12'd1;
            end
         end
         ST_STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (idx_q < last_q) begin
                  idx_d   = idx_q + 4'd1;
                  state_d = ST_LOAD;
               end else begin
                  idx_d   = '0;
                  state_d = ST_IDLE;
               end
            end else begin
               baud_d = baud_q + 12'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The line level is registered from the next state so tx never glitches.
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   assign tx       = tx_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != ST_IDLE) || !fifo_empty || halt_pending_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// Randomised and directed bench for out_uart_tx; a UART monitor checks every frame against a byte scoreboard.
module tb_out_uart_tx;
   localparam int CPB   = 4;
   localparam int DL2   = 2;
   localparam int DEPTH = 1 << DL2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] outval1 = '0;
   logic [15:0] outval2 = '0;
   logic [2:0]  outsel = '0;
   logic        outdisplay = 1'b0;
   logic        halting = 1'b0;
   logic        tx, busy, overflow;

   always #5 clock = ~clock;

   out_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
      .clock      (clock),
      .reset      (reset),
      .outval1    (outval1),
      .outval2    (outval2),
      .outsel     (outsel),
      .outdisplay (outdisplay),
      .halting    (halting),
      .tx         (tx),
      .busy       (busy),
      .overflow   (overflow)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb[$];
   bit         mon_en = 1'b0;
   bit         mon_busy = 1'b0;
   int         frames = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Reference: a record line is the printf of "<sel> <v1> <v2>" in uppercase hex, then CR LF.
   function automatic void push_line(input logic [2:0] sel, input logic [15:0] v1, input logic [15:0] v2);
      string s;
      s = $sformatf("%0d %04h %04h", sel, v1, v2);
      s = s.toupper();
      for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
      sb.push_back(8'h0D);
      sb.push_back(8'h0A);
   endfunction

   function automatic void push_halt();
      sb.push_back("H");
      sb.push_back(8'h0D);
      sb.push_back(8'h0A);
   endfunction

   // Called 1 time unit after a rising edge; returns 1 time unit after the edge that samples the strobe.
   task automatic strobe(input logic [2:0] sel, input logic [15:0] v1, input logic [15:0] v2, input bit accept);
      outsel     = sel;
      outval1    = v1;
      outval2    = v2;
      outdisplay = 1'b1;
      if (accept) push_line(sel, v1, v2);
      @(posedge clock);
      #1;
      outdisplay = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int c;
      c = 0;
      while ((busy || sb.size() != 0 || mon_busy) && c < 20000) begin
         @(posedge clock);
         #1;
         c++;
      end
      check({name, "_timeout"}, (c < 20000), 1);
      check({name, "_busy_end"}, busy, 0);
      check({name, "_drained"}, sb.size(), 0);
   endtask

   // UART monitor: 40 samples (start, 8 data, stop; CPB each) compared against the next expected byte.
   initial begin
      logic [39:0] got, expv;
      logic [7:0]  eb, gb;
      bit          aborted;
      forever begin
         @(negedge clock);
         if (mon_en && !reset && tx === 1'b0) begin
            mon_busy = 1'b1;
            aborted  = 1'b0;
            got      = '0;
            got[0]   = tx;
            for (int i = 1; i < 40; i++) begin
               @(negedge clock);
               if (reset) begin
                  aborted = 1'b1;
                  break;
               end
               got[i] = tx;
            end
            if (!aborted) begin
               frames++;
               for (int j = 0; j < 8; j++) gb[j] = got[4 + 4 * j + 1];
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte: got %02h, required no byte", gb);
               end else begin
                  eb = sb.pop_front();
                  for (int j = 0; j < 40; j++)
                     expv[j] = (j < 4) ? 1'b0 : (j >= 36) ? 1'b1 : eb[j / 4 - 1];
                  check($sformatf("frame_%02h_got_%02h", eb, gb), got, expv);
               end
            end
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int f0, lows, n;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_overflow", overflow, 0);
      mon_en = 1'b1;

      // Single record: latency and byte contents.
      strobe(3'd3, 16'h12AB, 16'h00FF, 1'b1);
      check("t1_tx_high_t1", tx, 1);
      check("t1_busy", busy, 1);
      @(posedge clock);
      #1;
      check("t1_tx_low_t2", tx, 0);
      wait_idle("t1");
      check("t1_overflow", overflow, 0);

      // Burst beyond capacity: one record is popped during the burst, so DEPTH+1 fit.
      for (int i = 0; i < 6; i++) strobe(3'(i), 16'(i), 16'(i), (i < DEPTH + 1));
      check("t2_overflow_set", overflow, 1);
      wait_idle("t2");
      check("t2_overflow_sticky", overflow, 1);

      // Halt while records are queued: records first, then a single halt line.
      strobe(3'd1, 16'hA5A5, 16'h0001, 1'b1);
      strobe(3'd7, 16'hFFFF, 16'h9C40, 1'b1);
      halting = 1'b1;
      push_halt();
      wait_idle("t3");
      halting = 1'b0;
      f0 = frames;
      repeat (20) @(posedge clock);
      #1 halting = 1'b1;
      repeat (20) @(posedge clock);
      #1 halting = 1'b0;
      repeat (150) @(posedge clock);
      #1;
      check("t3_no_second_halt", frames - f0, 0);
      check("t3_busy_after_toggle", busy, 0);
      check("t3_overflow_still", overflow, 1);

      // Reset in the middle of data bits.
      strobe(3'd2, 16'h3C5A, 16'h7E81, 1'b1);
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b1;
      sb.delete();
      @(posedge clock);
      #1;
      check("t4_tx_after_reset", tx, 1);
      check("t4_busy_after_reset", busy, 0);
      check("t4_overflow_after_reset", overflow, 0);
      reset = 1'b0;
      f0   = frames;
      lows = 0;
      repeat (200) begin
         @(posedge clock);
         #1;
         if (tx !== 1'b1) lows++;
      end
      check("t4_line_quiet", lows, 0);
      check("t4_no_frames", frames - f0, 0);
      strobe(3'd5, 16'hBEEF, 16'h0A19, 1'b1);
      wait_idle("t4_after");

      // Strobe and halt rise in the same cycle.
      halting = 1'b1;
      strobe(3'd0, 16'h0000, 16'hD00D, 1'b1);
      push_halt();
      wait_idle("t5");
      halting = 1'b0;

      // Random bursts from idle, small enough never to overflow.
      for (int b = 0; b < 5; b++) begin
         n = $urandom_range(1, DEPTH);
         for (int k = 0; k < n; k++) begin
            strobe(3'($urandom), 16'($urandom), 16'($urandom), 1'b1);
            if ($urandom_range(0, 1) == 1) begin
               @(posedge clock);
               #1;
            end
         end
         wait_idle($sformatf("rnd%0d", b));
      end
      check("final_overflow", overflow, 0);
      check("final_tx_idle", tx, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
